ex_fwd_scoreboard: RTL and testbench
====================================

// Module: ex_fwd_scoreboard
// PURPOSE
//  Parametrised EX-stage operand forwarding + RAW hazard unit; successor to the 2-port mem/wb forwarder.
//  Serves NUM_RD read ports from NUM_FWD_STAGES pipeline write-back taps (youngest first).
//  Adds a per-register busy scoreboard for long-latency ops (mul/div/cp0) and load-use stall detection.
//  Sits between regfile read outputs and the ALU operand muxes; stall_o drives the pipeline controller.
// PARAMETERS
//  NUM_RD          2   read ports served
//  NUM_FWD_STAGES  2   forwarding taps; index 0 = youngest (mem), highest = oldest (wb)
//  ADDR_W          5   register address width (2**ADDR_W architectural regs)
//  DATA_W          32  data width
// PORTS
//  clk_i            in   1                      clock
//  rst_i            in   1                      synchronous active-high reset
//  rd_en_i          in   NUM_RD                 port k reads a register this cycle
//  rd_addr_i        in   NUM_RD x ADDR_W        read addresses
//  rd_data_i        in   NUM_RD x DATA_W        raw regfile data
//  fwd_we_i         in   NUM_FWD_STAGES         tap s writes a register
//  fwd_waddr_i      in   NUM_FWD_STAGES x ADDR_W
//  fwd_wdata_i      in   NUM_FWD_STAGES x DATA_W
//  fwd_dvalid_i     in   NUM_FWD_STAGES         tap data ready (0 = load still in flight)
//  lop_issue_i      in   1                      long op issued this cycle
//  lop_waddr_i      in   ADDR_W                 long op destination
//  lop_issue_rdy_o  out  1                      destination not already busy (WAW guard)
//  lop_done_i       in   1                      long op result returns
//  lop_daddr_i      in   ADDR_W                 returning destination
//  lop_ddata_i      in   DATA_W                 returning result
//  rdata_o          out  NUM_RD x DATA_W        resolved operands
//  stall_o          out  1                      hold EX and earlier stages
//  pend_cnt_o       out  ADDR_W+1               registers currently busy
// BEHAVIOUR
//  - Reset (rst_i=1 at posedge): busy_q all 0, pend_cnt 0. While rst_i=1: rdata_o=0, stall_o=0, lop_issue_rdy_o=0.
//  - Register 0: never busy, never forwarded, always reads 0.
//  - Operand resolution per port k (combinational, 0-cycle), priority:
//    1 rd_en_i[k]=0 -> rd_data_i[k]; 2 lop_done_i && lop_daddr_i==addr -> lop_ddata_i;
//    3 lowest s with fwd_we_i[s] && fwd_waddr_i[s]==addr -> fwd_wdata_i[s]; 4 rd_data_i[k].
//  - stall_o=1 if any enabled port k (addr!=0): busy_q[addr] && !(lop_done_i && lop_daddr_i==addr);
//    or its selected tap s has fwd_dvalid_i[s]=0 (load-use). Older taps never override a younger unready one.
//  - Scoreboard (posedge): lop_issue_i && lop_issue_rdy_o && waddr!=0 sets busy; lop_done_i clears busy[daddr].
//    Same addr issue+done same cycle -> busy stays 1 (new issue wins). Issue with rdy=0 is ignored.
//  - lop_done_i on a non-busy reg: no state change, data still forwarded.
//  - pend_cnt_o = popcount(busy_q), registered, updated with busy_q; saturation impossible by width.
//  - Issue does not depend on stall_o; controller must not issue while stalled.
// CONFIGURATION
//  HAZ_PERF_CNT_EN defined: adds outputs perf_fwd_hits_o, perf_stall_cyc_o (32b each, wrap at 2**32,
//   reset 0); hits += 1 per port resolved by rule 2/3 in a non-stall cycle; stall_cyc += 1 per stall_o cycle.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Package ex_haz_pkg: reg_addr_t, word_t, NUM_ARCH_REGS, typedef fwd_tap_t {we,waddr,wdata,dvalid}.
//  Sub-module ex_fwd_port_sel (one instance per read port): priority mux + per-port stall flag.
//  Top holds busy_q, pend_cnt, optional perf counters, stall OR-reduce.
// TESTING
//  1 Tap0 we addr5=0xA, tap1 we addr5=0xB, port0 reads r5 -> rdata 0xA, stall 0.
//  2 Port1 reads r0 with tap0 writing r0=0xFF -> rdata 0, stall 0.
//  3 Tap0 we r7 dvalid=0, port0 reads r7 -> stall 1; next cycle dvalid=1 data 0x55 -> rdata 0x55, stall 0.
//  4 Issue lop r9; read r9 -> stall 1, pend_cnt 1; lop_done r9 data 0x1234 -> rdata 0x1234, stall 0, next pend_cnt 0.
//  5 Busy r9, issue r9 again -> lop_issue_rdy_o 0, busy unchanged; issue+done r3 same cycle -> r3 busy next.
//  6 Three regs busy, assert rst_i one cycle -> pend_cnt 0, no stalls, rdata 0 during reset.

Source files
------------

// File: rtl/ex_haz_pkg.sv
// Shared types and constants for the EX-stage forwarding / hazard unit.
//   ADDR_W / DATA_W  : register address and data widths (2**ADDR_W architectural regs)
//   reg_addr_t       : register address
//   word_t           : data word
//   pend_cnt_t       : busy-register count, one bit wider than an address so it can hold 2**ADDR_W
//   fwd_tap_t        : one write-back tap {we, waddr, wdata, dvalid}
//   popcount()       : number of set bits in a busy vector
package ex_haz_pkg;

  localparam int ADDR_W        = 5;
  localparam int DATA_W        = 32;
  localparam int NUM_ARCH_REGS = 2 ** ADDR_W;
  localparam int PERF_W        = 32;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W:0]   pend_cnt_t;

  typedef struct packed {
    logic      we;
    reg_addr_t waddr;
    word_t     wdata;
    logic      dvalid;
  } fwd_tap_t;

  function automatic pend_cnt_t popcount(input logic [NUM_ARCH_REGS-1:0] v);
    pend_cnt_t cnt;
    cnt = '0;
    for (int i = 0; i < NUM_ARCH_REGS; i++) begin
      cnt = cnt + pend_cnt_t'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/ex_fwd_scoreboard_if.sv
// Bus bundle between the EX stage / pipeline controller and ex_fwd_scoreboard.
//   rd_*        : per read port enable, address, raw regfile data
//   fwd_*       : per write-back tap (index 0 = youngest) write enable, address, data, data-valid
//   lop_issue_* : long-op issue request and destination; lop_issue_rdy_o is the ready side
//   lop_done_*  : long-op completion, destination and result
//   rdata_o     : resolved operands, stall_o : hold EX and earlier, pend_cnt_o : busy register count
// Handshake: a long op is accepted at a rising clock edge exactly when lop_issue_i and
// lop_issue_rdy_o are both high; lop_issue_i without ready is dropped (no state change), and
// the issuer must not depend on ready to decide whether to raise lop_issue_i.
// Modports: slave = the hazard unit, master = the driving pipeline.
interface ex_fwd_scoreboard_if #(
  parameter int NUM_RD         = 2,
  parameter int NUM_FWD_STAGES = 2
) ();
  import ex_haz_pkg::*;

  logic      [NUM_RD-1:0]         rd_en_i;
  reg_addr_t [NUM_RD-1:0]         rd_addr_i;
  word_t     [NUM_RD-1:0]         rd_data_i;
  logic      [NUM_FWD_STAGES-1:0] fwd_we_i;
  reg_addr_t [NUM_FWD_STAGES-1:0] fwd_waddr_i;
  word_t     [NUM_FWD_STAGES-1:0] fwd_wdata_i;
  logic      [NUM_FWD_STAGES-1:0] fwd_dvalid_i;
  logic                           lop_issue_i;
  reg_addr_t                      lop_waddr_i;
  logic                           lop_issue_rdy_o;
  logic                           lop_done_i;
  reg_addr_t                      lop_daddr_i;
  word_t                          lop_ddata_i;
  word_t     [NUM_RD-1:0]         rdata_o;
  logic                           stall_o;
  pend_cnt_t                      pend_cnt_o;

  modport slave (
    input  rd_en_i, rd_addr_i, rd_data_i,
    input  fwd_we_i, fwd_waddr_i, fwd_wdata_i, fwd_dvalid_i,
    input  lop_issue_i, lop_waddr_i, lop_done_i, lop_daddr_i, lop_ddata_i,
    output lop_issue_rdy_o, rdata_o, stall_o, pend_cnt_o
  );

  modport master (
    output rd_en_i, rd_addr_i, rd_data_i,
    output fwd_we_i, fwd_waddr_i, fwd_wdata_i, fwd_dvalid_i,
    output lop_issue_i, lop_waddr_i, lop_done_i, lop_daddr_i, lop_ddata_i,
    input  lop_issue_rdy_o, rdata_o, stall_o, pend_cnt_o
  );

endinterface

// File: rtl/ex_fwd_port_sel.sv
// Operand resolution for one read port (purely combinational).
//   en_i/addr_i/rd_data_i : read request and raw regfile data
//   busy_i                : scoreboard busy bit of addr_i
//   taps_i                : write-back taps, index 0 = youngest
//   lop_*                 : long-op completion bypass
//   rdata_o               : resolved operand
//   stall_o               : this port needs the pipeline held
//   hit_o                 : operand came from the completion bypass or a tap
// Priority: disabled -> raw data; r0 -> 0; completing long op; youngest matching tap; raw data.
module ex_fwd_port_sel
  import ex_haz_pkg::*;
#(
  parameter int NUM_FWD_STAGES = 2
) (
  input  logic                           en_i,
  input  reg_addr_t                      addr_i,
  input  word_t                          rd_data_i,
  input  logic                           busy_i,
  input  fwd_tap_t [NUM_FWD_STAGES-1:0]  taps_i,
  input  logic                           lop_done_i,
  input  reg_addr_t                      lop_daddr_i,
  input  word_t                          lop_ddata_i,
  output word_t                          rdata_o,
  output logic                           stall_o,
  output logic                           hit_o
);

  logic done_match;
  logic tap_found;

  always_comb begin
    rdata_o    = rd_data_i;
    stall_o    = 1'b0;
    hit_o      = 1'b0;
    tap_found  = 1'b0;
    done_match = lop_done_i && (lop_daddr_i == addr_i);
    if (en_i) begin
      if (addr_i == '0) begin
        rdata_o = '0;
      end else begin
        if (done_match) begin
          rdata_o = lop_ddata_i;
          hit_o   = 1'b1;
        end else begin
          // Youngest match wins; an older ready tap must not hide a younger load in flight.
          for (int s = 0; s < NUM_FWD_STAGES; s++) begin
            if (!tap_found && taps_i[s].we && (taps_i[s].waddr == addr_i)) begin
              tap_found = 1'b1;
              rdata_o   = taps_i[s].wdata;
              hit_o     = 1'b1;
              if (!taps_i[s].dvalid) begin
                stall_o = 1'b1;
              end
            end
          end
        end
        if (busy_i && !done_match) begin
          stall_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ex_fwd_scoreboard.sv
// EX-stage operand forwarding and RAW hazard unit with a long-op busy scoreboard.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus          : ex_fwd_scoreboard_if.slave (read ports, taps, long-op issue/done, results)
//   perf_fwd_hits_o, perf_stall_cyc_o : present only when HAZ_PERF_CNT_EN is defined;
//     forwarded operands in non-stall cycles, and stall cycles (both wrap at 2**32)
// Address/data widths come from ex_haz_pkg; NUM_RD / NUM_FWD_STAGES must match the interface.
module ex_fwd_scoreboard
  import ex_haz_pkg::*;
#(
  parameter int NUM_RD         = 2,
  parameter int NUM_FWD_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  ex_fwd_scoreboard_if.slave   bus
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]    perf_fwd_hits_o,
  output logic [PERF_W-1:0]    perf_stall_cyc_o
`endif
);

  fwd_tap_t [NUM_FWD_STAGES-1:0] taps;
  logic [NUM_ARCH_REGS-1:0]      busy_q, busy_d;
  pend_cnt_t                     pend_cnt_q, pend_cnt_d;
  word_t [NUM_RD-1:0]            port_data;
  logic  [NUM_RD-1:0]            port_stall;
  logic  [NUM_RD-1:0]            port_hit;
  logic                          stall_any;

  always_comb begin
    for (int s = 0; s < NUM_FWD_STAGES; s++) begin
      taps[s].we     = bus.fwd_we_i[s];
      taps[s].waddr  = bus.fwd_waddr_i[s];
      taps[s].wdata  = bus.fwd_wdata_i[s];
      taps[s].dvalid = bus.fwd_dvalid_i[s];
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_port
    ex_fwd_port_sel #(.NUM_FWD_STAGES(NUM_FWD_STAGES)) u_sel (
      .en_i        (bus.rd_en_i[k]),
      .addr_i      (bus.rd_addr_i[k]),
      .rd_data_i   (bus.rd_data_i[k]),
      .busy_i      (busy_q[bus.rd_addr_i[k]]),
      .taps_i      (taps),
      .lop_done_i  (bus.lop_done_i),
      .lop_daddr_i (bus.lop_daddr_i),
      .lop_ddata_i (bus.lop_ddata_i),
      .rdata_o     (port_data[k]),
      .stall_o     (port_stall[k]),
      .hit_o       (port_hit[k])
    );
  end

  assign stall_any           = |port_stall;
  assign bus.stall_o         = !rst_i && stall_any;
  assign bus.lop_issue_rdy_o = !rst_i && !busy_q[bus.lop_waddr_i];
  assign bus.rdata_o         = rst_i ? '0 : port_data;
  assign bus.pend_cnt_o      = pend_cnt_q;

  // Clear on completion first, then set on issue, so a same-register issue+done leaves it busy.
  always_comb begin
    busy_d = busy_q;
    if (bus.lop_done_i) begin
      busy_d[bus.lop_daddr_i] = 1'b0;
    end
    if (bus.lop_issue_i && bus.lop_issue_rdy_o) begin
      busy_d[bus.lop_waddr_i] = 1'b1;
    end
    busy_d[0]  = 1'b0;
    pend_cnt_d = popcount(busy_d);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [PERF_W-1:0] hits_q, hits_d;
  logic [PERF_W-1:0] stall_cyc_q, stall_cyc_d;
  logic [PERF_W-1:0] hit_sum;

  always_comb begin
    hit_sum = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      hit_sum = hit_sum + PERF_W'(port_hit[k]);
    end
    hits_d      = bus.stall_o ? hits_q : hits_q + hit_sum;
    stall_cyc_d = stall_cyc_q + PERF_W'(bus.stall_o);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hits_q      <= '0;
      stall_cyc_q <= '0;
    end else begin
      hits_q      <= hits_d;
      stall_cyc_q <= stall_cyc_d;
    end
  end

  assign perf_fwd_hits_o  = hits_q;
  assign perf_stall_cyc_o = stall_cyc_q;
`else
  logic unused_port_hit;
  assign unused_port_hit = ^port_hit;
`endif

endmodule

// File: tb/tb_ex_fwd_scoreboard.sv
// Self-checking bench for ex_fwd_scoreboard: directed scenarios followed by random traffic,
// every cycle compared against a register-file-level reference model of the forwarding rules.
module tb_ex_fwd_scoreboard;
  import ex_haz_pkg::*;

  localparam int NUM_RD = 2;
  localparam int NFS    = 2;

  logic clk;
  logic rst;

  ex_fwd_scoreboard_if #(.NUM_RD(NUM_RD), .NUM_FWD_STAGES(NFS)) bus ();

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_hits;
  logic [31:0] perf_stall;
`endif

  ex_fwd_scoreboard #(.NUM_RD(NUM_RD), .NUM_FWD_STAGES(NFS)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
`ifdef HAZ_PERF_CNT_EN
    ,
    .perf_fwd_hits_o  (perf_hits),
    .perf_stall_cyc_o (perf_stall)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus variables ----------------
  bit          s_rst;
  bit          s_en   [NUM_RD];
  int          s_addr [NUM_RD];
  logic [31:0] s_rdd  [NUM_RD];
  bit          s_twe  [NFS];
  int          s_twa  [NFS];
  logic [31:0] s_twd  [NFS];
  bit          s_tdv  [NFS];
  bit          s_iss;
  int          s_iwa;
  bit          s_dn;
  int          s_dwa;
  logic [31:0] s_dd;

  // ---------------- reference model state ----------------
  bit          busy_m [NUM_ARCH_REGS];
  bit          busy_nx[NUM_ARCH_REGS];
  bit          ref_stall;
  logic [31:0] ref_hits, ref_stall_cyc, ref_hits_nx, ref_stall_cyc_nx;

  // ---------------- scoreboard ----------------
  logic [DATA_W-1:0] exp_q[$];
  int checks;
  int errors;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    s_rst = 1'b0;
    for (int k = 0; k < NUM_RD; k++) begin
      s_en[k] = 1'b0; s_addr[k] = 0; s_rdd[k] = 32'hDEAD_0000 + k;
    end
    for (int s = 0; s < NFS; s++) begin
      s_twe[s] = 1'b0; s_twa[s] = 0; s_twd[s] = 32'h0; s_tdv[s] = 1'b1;
    end
    s_iss = 1'b0; s_iwa = 0; s_dn = 1'b0; s_dwa = 0; s_dd = 32'h0;
  endtask

  task automatic drive();
    rst = s_rst;
    for (int k = 0; k < NUM_RD; k++) begin
      bus.rd_en_i[k]   = s_en[k];
      bus.rd_addr_i[k] = reg_addr_t'(s_addr[k]);
      bus.rd_data_i[k] = s_rdd[k];
    end
    for (int s = 0; s < NFS; s++) begin
      bus.fwd_we_i[s]     = s_twe[s];
      bus.fwd_waddr_i[s]  = reg_addr_t'(s_twa[s]);
      bus.fwd_wdata_i[s]  = s_twd[s];
      bus.fwd_dvalid_i[s] = s_tdv[s];
    end
    bus.lop_issue_i = s_iss;
    bus.lop_waddr_i = reg_addr_t'(s_iwa);
    bus.lop_done_i  = s_dn;
    bus.lop_daddr_i = reg_addr_t'(s_dwa);
    bus.lop_ddata_i = s_dd;
  endtask

  // Drive at the falling edge, evaluate the model and compare one time unit later.
  task automatic settle();
    int  pend;
    bit  exp_rdy;
    int  hits;
    @(negedge clk);
    drive();
    #1;
    ref_stall = 1'b0;
    hits = 0;
    for (int k = 0; k < NUM_RD; k++) begin
      logic [31:0] v;
      int          a;
      int          match_taps[$];
      a = s_addr[k];
      v = s_rdd[k];
      if (s_rst) begin
        v = 32'h0;
      end else if (s_en[k]) begin
        if (a == 0) begin
          v = 32'h0;
        end else begin
          if (s_dn && s_dwa == a) begin
            v = s_dd;
            hits++;
          end else begin
            for (int s = 0; s < NFS; s++) if (s_twe[s] && s_twa[s] == a) match_taps.push_back(s);
            if (match_taps.size() > 0) begin
              v = s_twd[match_taps[0]];
              hits++;
              if (!s_tdv[match_taps[0]]) ref_stall = 1'b1;
            end
          end
          if (busy_m[a] && !(s_dn && s_dwa == a)) ref_stall = 1'b1;
        end
      end
      exp_q.push_back(v);
    end
    for (int k = 0; k < NUM_RD; k++) begin
      check($sformatf("rdata%0d", k), 64'(bus.rdata_o[k]), 64'(exp_q.pop_front()));
    end
    check("stall", 64'(bus.stall_o), 64'(ref_stall));
    exp_rdy = !s_rst && !busy_m[s_iwa];
    check("issue_rdy", 64'(bus.lop_issue_rdy_o), 64'(exp_rdy));
    pend = 0;
    foreach (busy_m[i]) pend += int'(busy_m[i]);
    check("pend_cnt", 64'(bus.pend_cnt_o), 64'(pend));
`ifdef HAZ_PERF_CNT_EN
    check("perf_hits", 64'(perf_hits), 64'(ref_hits));
    check("perf_stall", 64'(perf_stall), 64'(ref_stall_cyc));
`endif
    // Next scoreboard contents: completion frees, accepted issue claims, r0 never held.
    busy_nx = busy_m;
    if (s_rst) begin
      foreach (busy_nx[i]) busy_nx[i] = 1'b0;
      ref_hits_nx = 32'h0;
      ref_stall_cyc_nx = 32'h0;
    end else begin
      if (s_dn) busy_nx[s_dwa] = 1'b0;
      if (s_iss && exp_rdy && s_iwa != 0) busy_nx[s_iwa] = 1'b1;
      ref_hits_nx = ref_stall ? ref_hits : ref_hits + 32'(hits);
      ref_stall_cyc_nx = ref_stall_cyc + 32'(ref_stall);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    busy_m = busy_nx;
    ref_hits = ref_hits_nx;
    ref_stall_cyc = ref_stall_cyc_nx;
  endtask

  task automatic cycle();
    settle();
    advance();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    checks = 0;
    errors = 0;
    ref_hits = 32'h0;
    ref_stall_cyc = 32'h0;
    foreach (busy_m[i]) busy_m[i] = 1'b0;
    idle_inputs();
    s_rst = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    s_rst = 1'b0;

    // Idle after reset
    idle_inputs();
    cycle();

    // 1: youngest tap wins
    idle_inputs();
    s_twe[0] = 1; s_twa[0] = 5; s_twd[0] = 32'hA;
    s_twe[1] = 1; s_twa[1] = 5; s_twd[1] = 32'hB;
    s_en[0] = 1; s_addr[0] = 5;
    settle();
    check("t1_rdata", 64'(bus.rdata_o[0]), 64'h0A);
    check("t1_stall", 64'(bus.stall_o), 64'h0);
    advance();

    // 2: r0 reads zero even if a tap writes it
    idle_inputs();
    s_twe[0] = 1; s_twa[0] = 0; s_twd[0] = 32'hFF;
    s_en[1] = 1; s_addr[1] = 0; s_rdd[1] = 32'h1111;
    settle();
    check("t2_rdata", 64'(bus.rdata_o[1]), 64'h0);
    check("t2_stall", 64'(bus.stall_o), 64'h0);
    advance();

    // 3: load-use stall, then data arrives
    idle_inputs();
    s_twe[0] = 1; s_twa[0] = 7; s_tdv[0] = 0; s_twd[0] = 32'h0;
    s_twe[1] = 1; s_twa[1] = 7; s_twd[1] = 32'h77;
    s_en[0] = 1; s_addr[0] = 7;
    settle();
    check("t3_stall", 64'(bus.stall_o), 64'h1);
    advance();
    s_tdv[0] = 1; s_twd[0] = 32'h55;
    settle();
    check("t3_rdata", 64'(bus.rdata_o[0]), 64'h55);
    check("t3_stall_clr", 64'(bus.stall_o), 64'h0);
    advance();

    // 4: long op on r9
    idle_inputs();
    s_iss = 1; s_iwa = 9;
    cycle();
    idle_inputs();
    s_en[0] = 1; s_addr[0] = 9;
    settle();
    check("t4_stall", 64'(bus.stall_o), 64'h1);
    check("t4_pend", 64'(bus.pend_cnt_o), 64'h1);
    advance();
    s_dn = 1; s_dwa = 9; s_dd = 32'h1234;
    settle();
    check("t4_rdata", 64'(bus.rdata_o[0]), 64'h1234);
    check("t4_stall_clr", 64'(bus.stall_o), 64'h0);
    advance();
    idle_inputs();
    settle();
    check("t4_pend_clr", 64'(bus.pend_cnt_o), 64'h0);
    advance();

    // 5: WAW guard and same-cycle issue+done
    idle_inputs();
    s_iss = 1; s_iwa = 9;
    cycle();
    settle();
    check("t5_rdy", 64'(bus.lop_issue_rdy_o), 64'h0);
    advance();
    idle_inputs();
    s_iss = 1; s_iwa = 3; s_dn = 1; s_dwa = 3; s_dd = 32'h3;
    cycle();
    idle_inputs();
    s_en[1] = 1; s_addr[1] = 3;
    settle();
    check("t5_r3_busy", 64'(bus.stall_o), 64'h1);
    check("t5_pend", 64'(bus.pend_cnt_o), 64'h2);
    advance();

    // 6: reset with three busy registers
    idle_inputs();
    s_iss = 1; s_iwa = 10;
    cycle();
    idle_inputs();
    s_rst = 1; s_en[0] = 1; s_addr[0] = 9; s_twe[0] = 1; s_twa[0] = 9; s_twd[0] = 32'h99;
    settle();
    check("t6_rdata_rst", 64'(bus.rdata_o[0]), 64'h0);
    check("t6_stall_rst", 64'(bus.stall_o), 64'h0);
    check("t6_rdy_rst", 64'(bus.lop_issue_rdy_o), 64'h0);
    advance();
    idle_inputs();
    s_en[0] = 1; s_addr[0] = 9;
    settle();
    check("t6_pend", 64'(bus.pend_cnt_o), 64'h0);
    check("t6_stall", 64'(bus.stall_o), 64'h0);
    advance();

    // Random traffic over a small register window to force collisions
    for (int n = 0; n < 2000; n++) begin
      idle_inputs();
      s_rst = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < NUM_RD; k++) begin
        s_en[k]   = ($urandom_range(0, 3) != 0);
        s_addr[k] = $urandom_range(0, 7);
        s_rdd[k]  = $urandom;
      end
      for (int s = 0; s < NFS; s++) begin
        s_twe[s] = ($urandom_range(0, 1) == 1);
        s_twa[s] = $urandom_range(0, 7);
        s_twd[s] = $urandom;
        s_tdv[s] = ($urandom_range(0, 4) != 0);
      end
      s_iss = ($urandom_range(0, 2) == 0);
      s_iwa = $urandom_range(0, 7);
      s_dn  = ($urandom_range(0, 3) == 0);
      s_dwa = $urandom_range(0, 7);
      s_dd  = $urandom;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
